// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order reorder buffer. Allocates entries from rename, marks
//               them complete by tag and retires completed entries strictly in
//               program order, at most one per cycle.
//               Optional protocol checking is enabled by defining ROB_CHECK_EN;
//               without it err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = $clog2(DEPTH),
    parameter int AREG_W = 5,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_rd,
    input  logic [AREG_W-1:0] alloc_rd,
    input  logic [PREG_W-1:0] alloc_pd,
    input  logic [PREG_W-1:0] alloc_old_pd,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cmpl_valid,
    input  logic [TAG_W-1:0]  cmpl_tag,
    output logic              retire_valid,
    output logic              retire_has_rd,
    output logic [AREG_W-1:0] retire_rd,
    output logic [PREG_W-1:0] retire_pd,
    output logic [PREG_W-1:0] retire_old_pd,
    output logic [TAG_W:0]    count,
    output logic              err
);

    localparam logic [TAG_W:0] c_full = (TAG_W+1)'(DEPTH);

    // Per-entry state
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic              r_has_rd [DEPTH];
    logic [AREG_W-1:0] r_rd     [DEPTH];
    logic [PREG_W-1:0] r_pd     [DEPTH];
    logic [PREG_W-1:0] r_old_pd [DEPTH];

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic              w_alloc_fire;
    logic              w_retire_fire;

    // Full check uses the pre-edge count, so a same-edge retire never frees a slot
    assign alloc_ready   = (r_count != c_full);
    assign alloc_tag     = r_tail;
    assign count         = r_count;
    assign w_alloc_fire  = alloc_valid && alloc_ready;
    assign w_retire_fire = r_valid[r_head] && r_done[r_head];

    // Pointers, occupancy, valid/done bits and the registered retire port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_valid       <= '0;
            r_done        <= '0;
            retire_valid  <= 1'b0;
            retire_has_rd <= 1'b0;
            retire_rd     <= '0;
            retire_pd     <= '0;
            retire_old_pd <= '0;
        end else if (flush) begin
            // retire_* payload deliberately holds across a flush
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_valid      <= '0;
            r_done       <= '0;
            retire_valid <= 1'b0;
        end else begin
            // A completion to the slot being allocated sees valid=0 and is dropped
            if (cmpl_valid && r_valid[cmpl_tag]) begin
                r_done[cmpl_tag] <= 1'b1;
            end
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            retire_valid <= w_retire_fire;
            if (w_retire_fire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
                retire_has_rd   <= r_has_rd[r_head];
                retire_rd       <= r_rd[r_head];
                retire_pd       <= r_pd[r_head];
                retire_old_pd   <= r_old_pd[r_head];
            end
            r_count <= r_count + (TAG_W+1)'(w_alloc_fire) - (TAG_W+1)'(w_retire_fire);
        end
    end

    // Entry payload storage; only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_alloc_fire) begin
            r_has_rd[r_tail] <= alloc_has_rd;
            r_rd[r_tail]     <= alloc_rd;
            r_pd[r_tail]     <= alloc_pd;
            r_old_pd[r_tail] <= alloc_old_pd;
        end
    end

`ifdef ROB_CHECK_EN
    logic r_err;
    logic w_cmpl_bad;
    logic w_alloc_bad;

    assign w_cmpl_bad  = cmpl_valid && (!r_valid[cmpl_tag] || r_done[cmpl_tag]);
    assign w_alloc_bad = alloc_valid && !alloc_ready;

    // Sticky protocol error; inputs are ignored on a flush edge so nothing is flagged there
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (!flush && (w_cmpl_bad || w_alloc_bad)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer (DEPTH=16): a vector
//               table for in-order retire plus directed full/flush/reset runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int AREG_W = 5;
    localparam int PREG_W = 6;

`ifdef ROB_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              flush;
    logic              alloc_valid;
    logic              alloc_ready;
    logic              alloc_has_rd;
    logic [AREG_W-1:0] alloc_rd;
    logic [PREG_W-1:0] alloc_pd;
    logic [PREG_W-1:0] alloc_old_pd;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cmpl_valid;
    logic [TAG_W-1:0]  cmpl_tag;
    logic              retire_valid;
    logic              retire_has_rd;
    logic [AREG_W-1:0] retire_rd;
    logic [PREG_W-1:0] retire_pd;
    logic [PREG_W-1:0] retire_old_pd;
    logic [TAG_W:0]    count;
    logic              err;

    int total = 0;
    int bad   = 0;

    reorder_buffer #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .AREG_W(AREG_W),
        .PREG_W(PREG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_has_rd (alloc_has_rd),
        .alloc_rd     (alloc_rd),
        .alloc_pd     (alloc_pd),
        .alloc_old_pd (alloc_old_pd),
        .alloc_tag    (alloc_tag),
        .cmpl_valid   (cmpl_valid),
        .cmpl_tag     (cmpl_tag),
        .retire_valid (retire_valid),
        .retire_has_rd(retire_has_rd),
        .retire_rd    (retire_rd),
        .retire_pd    (retire_pd),
        .retire_old_pd(retire_old_pd),
        .count        (count),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic       hrd;
        logic [4:0] rd;
        logic [5:0] pd;
        logic [5:0] opd;
        logic       cv;
        logic [3:0] ct;
        logic       e_ready;
        logic [3:0] e_tag;
        logic [4:0] e_count;
        logic       e_rv;
        logic       e_rhrd;
        logic [4:0] e_rrd;
        logic [5:0] e_rpd;
        logic [5:0] e_ropd;
        logic       e_err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_has_rd = 1'b0;
        alloc_rd     = '0;
        alloc_pd     = '0;
        alloc_old_pd = '0;
        cmpl_valid   = 1'b0;
        cmpl_tag     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".count"},         int'(count), 0);
        chk({tag, ".alloc_ready"},   int'(alloc_ready), 1);
        chk({tag, ".alloc_tag"},     int'(alloc_tag), 0);
        chk({tag, ".retire_valid"},  int'(retire_valid), 0);
        chk({tag, ".retire_has_rd"}, int'(retire_has_rd), 0);
        chk({tag, ".retire_rd"},     int'(retire_rd), 0);
        chk({tag, ".retire_pd"},     int'(retire_pd), 0);
        chk({tag, ".retire_old_pd"}, int'(retire_old_pd), 0);
        chk({tag, ".err"},           int'(err), 0);
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [5:0] pd, input logic [5:0] opd);
        alloc_valid  = 1'b1;
        alloc_has_rd = 1'b1;
        alloc_rd     = rd;
        alloc_pd     = pd;
        alloc_old_pd = opd;
        tick();
        idle_inputs();
    endtask

    task automatic cmpl(input logic [3:0] t);
        cmpl_valid = 1'b1;
        cmpl_tag   = t;
        tick();
        idle_inputs();
    endtask

    initial begin
        // av hrd rd pd opd cv ct | ready tag count rv rhrd rrd rpd ropd err
        vecs[0]  = '{1,1,1,33,1, 0,0,  1,1,1, 0,0,0,0,0, 0};
        vecs[1]  = '{1,0,2,34,2, 0,0,  1,2,2, 0,0,0,0,0, 0};
        vecs[2]  = '{1,1,3,35,3, 0,0,  1,3,3, 0,0,0,0,0, 0};
        vecs[3]  = '{0,0,0,0,0,  1,2,  1,3,3, 0,0,0,0,0, 0};
        vecs[4]  = '{0,0,0,0,0,  1,1,  1,3,3, 0,0,0,0,0, 0};
        vecs[5]  = '{0,0,0,0,0,  1,0,  1,3,3, 0,0,0,0,0, 0};
        vecs[6]  = '{0,0,0,0,0,  0,0,  1,3,2, 1,1,1,33,1, 0};
        vecs[7]  = '{0,0,0,0,0,  0,0,  1,3,1, 1,0,2,34,2, 0};
        vecs[8]  = '{0,0,0,0,0,  0,0,  1,3,0, 1,1,3,35,3, 0};
        vecs[9]  = '{0,0,0,0,0,  0,0,  1,3,0, 0,1,3,35,3, 0};
        // completion of tag 7 on an empty buffer: only err may change
        vecs[10] = '{0,0,0,0,0,  1,7,  1,3,0, 0,1,3,35,3, ERR_ON};
        vecs[11] = '{0,0,0,0,0,  0,0,  1,3,0, 0,1,3,35,3, ERR_ON};
        // completion aimed at the slot being allocated is ignored
        vecs[12] = '{1,1,4,36,4, 1,3,  1,4,1, 0,1,3,35,3, ERR_ON};
        vecs[13] = '{0,0,0,0,0,  0,0,  1,4,1, 0,1,3,35,3, ERR_ON};
        vecs[14] = '{0,0,0,0,0,  1,3,  1,4,1, 0,1,3,35,3, ERR_ON};
        vecs[15] = '{0,0,0,0,0,  0,0,  1,4,0, 1,1,4,36,4, ERR_ON};

        rst = 1'b1;
        idle_inputs();
        do_reset();
        chk_reset_state("reset0");

        // In-order retire with out-of-order completion
        for (int i = 0; i < 16; i++) begin
            alloc_valid  = vecs[i].av;
            alloc_has_rd = vecs[i].hrd;
            alloc_rd     = vecs[i].rd;
            alloc_pd     = vecs[i].pd;
            alloc_old_pd = vecs[i].opd;
            cmpl_valid   = vecs[i].cv;
            cmpl_tag     = vecs[i].ct;
            tick();
            chk($sformatf("v%0d.ready", i),  int'(alloc_ready),   int'(vecs[i].e_ready));
            chk($sformatf("v%0d.tag", i),    int'(alloc_tag),     int'(vecs[i].e_tag));
            chk($sformatf("v%0d.count", i),  int'(count),         int'(vecs[i].e_count));
            chk($sformatf("v%0d.rv", i),     int'(retire_valid),  int'(vecs[i].e_rv));
            chk($sformatf("v%0d.rhrd", i),   int'(retire_has_rd), int'(vecs[i].e_rhrd));
            chk($sformatf("v%0d.rrd", i),    int'(retire_rd),     int'(vecs[i].e_rrd));
            chk($sformatf("v%0d.rpd", i),    int'(retire_pd),     int'(vecs[i].e_rpd));
            chk($sformatf("v%0d.ropd", i),   int'(retire_old_pd), int'(vecs[i].e_ropd));
            chk($sformatf("v%0d.err", i),    int'(err),           int'(vecs[i].e_err));
        end
        idle_inputs();

        // err is sticky until rst
        tick();
        chk("err_sticky", int'(err), int'(ERR_ON));
        do_reset();
        chk_reset_state("reset1");

        // Fill to DEPTH, refuse one more, then wrap
        for (int i = 0; i < DEPTH; i++) begin
            alloc(5'(i), 6'(i + 16), 6'(i));
        end
        chk("full.count", int'(count), 16);
        chk("full.ready", int'(alloc_ready), 0);
        chk("full.tag",   int'(alloc_tag), 0);
        alloc(5'd30, 6'd60, 6'd61);
        chk("refused.count", int'(count), 16);
        chk("refused.tag",   int'(alloc_tag), 0);
        chk("refused.err",   int'(err), int'(ERR_ON));
        cmpl(4'd0);
        chk("head_done.rv", int'(retire_valid), 0);
        tick();
        chk("wrap_retire.rv",    int'(retire_valid), 1);
        chk("wrap_retire.rd",    int'(retire_rd), 0);
        chk("wrap_retire.pd",    int'(retire_pd), 16);
        chk("wrap_retire.count", int'(count), 15);
        chk("wrap_retire.ready", int'(alloc_ready), 1);
        chk("wrap_retire.tag",   int'(alloc_tag), 0);
        alloc(5'd20, 6'd40, 6'd41);
        chk("wrap_alloc.count", int'(count), 16);
        chk("wrap_alloc.tag",   int'(alloc_tag), 1);

        // Full, head done, alloc held: retire fires but alloc refused this edge
        cmpl(4'd1);
        alloc_valid  = 1'b1;
        alloc_has_rd = 1'b1;
        alloc_rd     = 5'd21;
        alloc_pd     = 6'd42;
        alloc_old_pd = 6'd43;
        tick();
        chk("same_edge.rv",    int'(retire_valid), 1);
        chk("same_edge.rrd",   int'(retire_rd), 1);
        chk("same_edge.count", int'(count), 15);
        chk("same_edge.tag",   int'(alloc_tag), 1);
        tick();
        chk("next_edge.count", int'(count), 16);
        chk("next_edge.tag",   int'(alloc_tag), 2);
        chk("next_edge.rv",    int'(retire_valid), 0);
        idle_inputs();

        // Flush with live and partially completed entries
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(5'(i + 8), 6'(i + 48), 6'(i + 8));
        end
        cmpl(4'd1);
        cmpl(4'd2);
        chk("pre_flush.count", int'(count), 5);
        chk("pre_flush.rv",    int'(retire_valid), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.count", int'(count), 0);
        chk("flush.rv",    int'(retire_valid), 0);
        chk("flush.tag",   int'(alloc_tag), 0);
        tick();
        chk("post_flush.rv", int'(retire_valid), 0);
        alloc(5'd7, 6'd9, 6'd7);
        chk("post_flush.tag",   int'(alloc_tag), 1);
        chk("post_flush.count", int'(count), 1);

        // rst while 4 entries live and head about to retire
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(5'(i + 1), 6'(i + 40), 6'(i + 1));
        end
        cmpl(4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("mid_rst");
        tick();
        chk("mid_rst.after_rv", int'(retire_valid), 0);
        chk("mid_rst.after_count", int'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
